// File: rtl/logic_unit_pipe.sv
// Registered 8-op bitwise logic unit feeding a DEPTH-entry result FIFO with zero/parity flags.
// Optional accumulator chaining is enabled by defining LOGIC_UNIT_ACC_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [WIDTH-1:0]         in_x,
  input  logic [WIDTH-1:0]         in_y,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_parity,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             zero_mem [DEPTH];
  logic             par_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [FW-1:0]    fill_nxt;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] result;
  logic             res_zero;
  logic             res_par;

  // in_ready looks only at stored occupancy, so a full FIFO refuses input even during a pop
  assign in_ready  = (fill < DEPTH_F);
  assign out_valid = (fill != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] acc;

  assign op_x = in_op[3] ? acc : in_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (push) begin
      acc <= result;
    end
  end
`else
  logic unused_acc_inputs;

  assign op_x              = in_x;
  assign unused_acc_inputs = ^{in_op[3], acc_clr};
`endif

  always_comb begin
    result = '0;
    case (in_op[2:0])
      3'd0: result = op_x & in_y;
      3'd1: result = op_x | in_y;
      3'd2: result = op_x ^ in_y;
      3'd3: result = ~op_x;
      3'd4: result = ~(op_x & in_y);
      3'd5: result = ~(op_x | in_y);
      3'd6: result = ~(op_x ^ in_y);
      default: result = in_y;
    endcase
  end

  assign res_zero = (result == '0);
  assign res_par  = ^result;

  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    fill_nxt   = fill;
    case ({push, pop})
      2'b10:   fill_nxt = fill + FW'(1);
      2'b01:   fill_nxt = fill - FW'(1);
      default: fill_nxt = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= result;
      zero_mem[wr_ptr] <= res_zero;
      par_mem[wr_ptr]  <= res_par;
    end
  end

  // The head register is reloaded from the next head slot, bypassing the write when that slot is being filled now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      out_data   <= '0;
      out_zero   <= 1'b1;
      out_parity <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      fill   <= fill_nxt;
      if ((push || pop) && (fill_nxt != '0)) begin
        if (push && (wr_ptr == rd_ptr_nxt)) begin
          out_data   <= result;
          out_zero   <= res_zero;
          out_parity <= res_par;
        end else begin
          out_data   <= data_mem[rd_ptr_nxt];
          out_zero   <= zero_mem[rd_ptr_nxt];
          out_parity <= par_mem[rd_ptr_nxt];
        end
      end
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the team's 4-bit AND/OR/XOR/NOT digit blocks. It accepts an operand pair and an opcode over a valid/ready handshake, computes one of eight bitwise operations at WIDTH bits, and queues the results in a DEPTH-entry output FIFO with zero/parity flags. An optional accumulator lets successive operations chain on the previous result. It sits between the operand-entry logic and the display/readout path of the calculator datapath.

## Interface
- WIDTH, 8: operand and result width in bits; minimum 1.
- DEPTH, 4: output FIFO entries; must be a power of 2 and at least 2.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept this cycle.
- in_op  in  4  bits [2:0] select the operation; bit [3] selects the accumulator as the x operand.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  WIDTH  result at the FIFO head.
- out_zero  out  1  out_data == 0, stored with the entry.
- out_parity  out  1  XOR-reduction of out_data, stored with the entry.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Opcodes for in_op[2:0]:
  - 0: AND
  - 1: OR
  - 2: XOR
  - 3: NOT x (y ignored)
  - 4: NAND
  - 5: NOR
  - 6: XNOR
  - 7: PASS y
- All operations are bitwise across the full WIDTH. There is no carry and no width growth.
- Accept occurs when in_valid and in_ready are both high.
- On accept, the result and its flags are written to the FIFO tail, and fill increments.
- Pop occurs when out_valid and out_ready are both high. On pop, the head advances and fill decrements.
- On a simultaneous accept and pop, fill is unchanged and both actions occur.
- in_ready = (fill < DEPTH). It is registered-state-derived only and never depends combinationally on out_ready. A full FIFO therefore rejects input even when a pop happens in the same cycle.
- out_valid = (fill != 0).
- Read and write pointers wrap modulo DEPTH.
- While out_valid is 0, out_data and the flags show the last popped entry, or 0 after reset. The bench checks them only when out_valid is 1.
- Accumulator (acc, WIDTH bits, present only with the macro):
  - When in_op[3] is 1, acc replaces in_x as the x operand.
  - On every accept, acc is updated with the result.
  - acc_clr sets acc to 0 on the next edge.
  - acc_clr asserted in the same cycle as an accept: the operation uses the old acc, the result is still enqueued, and acc becomes 0 (clear wins).
  - acc_clr alone does not touch the FIFO.
- Reset (rst_n low, at any time including mid-transfer):
  - FIFO emptied: fill = 0, out_valid = 0, in_ready = 1.
  - out_data = 0, out_zero = 1, out_parity = 0.
  - acc = 0, pointers = 0.
  - In-flight data is discarded.

## Timing
- Latency: a result accepted at edge N is visible as the head (out_valid = 1) after edge N when the FIFO was empty.
- Throughput is one operation per cycle when out_ready is held high.
- The FIFO head is registered. out_data, out_zero and out_parity change only on clock edges or on reset.
- in_ready falls in the cycle after the accept that makes fill = DEPTH. It rises in the cycle after the first pop.
- Accumulator chaining supports back-to-back accepts: the operation at edge N+1 sees the acc value written at edge N.

## Configuration
- LOGIC_UNIT_ACC_EN defined: the acc register, the in_op[3] operand select and acc_clr are implemented as described.
- LOGIC_UNIT_ACC_EN undefined:
  - in_op[3] and acc_clr are ignored and x is always in_x.
  - No acc register is synthesised.
  - The ports remain present so the interface is identical in both builds.

## Test plan
- Reset, then WIDTH=8, x=0xF0, y=0x3C across ops 0..7 with out_ready=1: results 0x30, 0xFC, 0xCC, 0x0F, 0xCF, 0x03, 0x33, 0x3C in order, each 1 cycle after accept; out_zero=0 throughout; parity as computed.
- out_ready=0, push 5 items with DEPTH=4: 4 accepted, fill=4, in_ready=0 during the 5th; raise out_ready and pop 4 in FIFO order; in_ready returns 1 the cycle after the first pop.
- Full FIFO with simultaneous in_valid and out_ready: no accept that cycle; fill goes 4→3; the next cycle accepts.
- Accumulator (macro on): acc_clr, then OR x=0x01 with in_op[3]=0, then OR y=0x80 with in_op[3]=1: outputs 0x01 then 0x81. XOR y=0x81 with in_op[3]=1 plus acc_clr in the same cycle: output 0x00 with out_zero=1, and acc=0 afterwards.
- Assert rst_n low mid-stream with fill=3 and acc=0x55: out_valid=0, fill=0 and in_ready=1 immediately; subsequent ops using in_op[3] use acc=0.
- Macro off: repeat the accumulator test; in_op[3] is ignored, so outputs equal those computed with in_x.
